// File: rtl/loader_pkg.sv
// Types and constants shared by the program loader and its byte assembler.
package loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Collects bytes little-endian into a word; o_word_ready flags the byte that completes it.
module byte_assembler
  import loader_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_clear,
  input  logic              i_byte_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [DWIDTH-1:0] o_word,
  output logic              o_word_ready
);

  localparam int BYTES = DWIDTH / BYTE_W;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(BYTES - 1);

  logic [CW-1:0]     r_cnt;
  logic [DWIDTH-1:0] r_word;
  logic [DWIDTH-1:0] w_shifted;

  // Shifting right places the first byte of a word at bits [7:0] once the word is full.
  generate
    if (BYTES > 1) begin : g_multi
      assign w_shifted = {i_byte, r_word[DWIDTH-1:BYTE_W]};
    end else begin : g_single
      assign w_shifted = i_byte;
    end
  endgenerate

  assign o_word_ready = i_byte_en && (r_cnt == C_LAST);
  assign o_word       = r_word;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
    end else if (i_byte_en) begin
      r_word <= w_shifted;
      r_cnt  <= o_word_ready ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory
// while holding the core stalled.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, core running
// ST_LEN   | accepting the word-count byte (0 means a full memory)
// ST_DATA  | accepting data bytes of the current word
// ST_WRITE | one-cycle memory write of the assembled word
// ST_CHECK | accepting the checksum byte
// ST_DONE  | load good, core released, waiting for a restart
// ST_ERROR | load aborted, core kept stalled, waiting for a restart
module prog_loader
  import loader_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [AWIDTH-1:0] waddr,
  output logic [DWIDTH-1:0] wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [AWIDTH:0] C_MAX_WORDS = (AWIDTH + 1)'(1) << AWIDTH;

  state_t            r_state;
  logic [AWIDTH:0]   r_target;
  logic [AWIDTH:0]   r_words;
  logic [BYTE_W-1:0] r_csum;

  logic              w_accept;
  logic              w_data_accept;
  logic              w_word_ready;
  logic              w_start_ok;
  logic              w_len_bad;
  logic [AWIDTH:0]   w_words_next;
  logic [DWIDTH-1:0] w_word;

  assign w_accept      = in_valid && in_ready;
  assign w_data_accept = w_accept && (r_state == ST_DATA);
  assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERROR));
  assign w_len_bad     = 32'(in_data) > 32'(C_MAX_WORDS);
  assign w_words_next  = r_words + (AWIDTH + 1)'(1);
  assign wdata         = w_word;

  byte_assembler #(
    .DWIDTH(DWIDTH)
  ) u_byte_assembler (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_clear     (w_start_ok),
    .i_byte_en   (w_data_accept),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_ready(w_word_ready)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_words  <= '0;
      r_csum   <= '0;
      in_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_state  <= ST_LEN;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            waddr    <= '0;
            r_words  <= '0;
            r_csum   <= '0;
          end
        end
        ST_LEN: begin
          if (w_accept) begin
            if (w_len_bad) begin
              r_state  <= ST_ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              r_state  <= ST_DATA;
              r_target <= (in_data == '0) ? C_MAX_WORDS : (AWIDTH + 1)'(in_data);
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_csum <= r_csum ^ in_data;
            if (w_word_ready) begin
              r_state  <= ST_WRITE;
              in_ready <= 1'b0;
              we       <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // A full-memory load wraps waddr back to 0 after the last word.
          waddr    <= waddr + AWIDTH'(1);
          r_words  <= w_words_next;
          in_ready <= 1'b1;
          r_state  <= (w_words_next == r_target) ? ST_CHECK : ST_DATA;
        end
        ST_CHECK: begin
          if (w_accept) begin
            in_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_state  <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              error   <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          in_ready <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a stream-level reference model.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, we, cpu_hold, done, error;
  logic [5:0]  waddr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  prog_loader #(.DWIDTH(32), .AWIDTH(6)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  stim_q[$];
  logic [31:0] words_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          exp_done, exp_err;
  int          exp_waddr_end;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write strobe must match the next expected (address, word) pair.
  always @(negedge clk) begin
    if (n_rst && we) begin
      if (exp_q.size() == 0) begin
        check_eq("we_unexpected", {58'd0, waddr}, 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("waddr", waddr, e.addr);
        check_eq("wdata", wdata, e.data);
      end
    end
  end

  // Reference: the byte stream and the writes/flags it must produce.
  task automatic build(input logic [7:0] lenb, input logic [7:0] cmask);
    int         n;
    logic [7:0] x;
    logic [31:0] w;
    wr_t        e;
    stim_q.delete();
    exp_q.delete();
    n = (lenb == 8'd0) ? 64 : int'(lenb);
    stim_q.push_back(lenb);
    if (n > 64) begin
      exp_done      = 1'b0;
      exp_err       = 1'b1;
      exp_waddr_end = 0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w      = words_q[i];
      e.addr = 6'(i);
      e.data = w;
      exp_q.push_back(e);
      for (int b = 0; b < 4; b++) begin
        stim_q.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
    end
    stim_q.push_back(x ^ cmask);
    exp_done      = (cmask == 8'h00);
    exp_err       = !exp_done;
    exp_waddr_end = n % 64;
  endtask

  // Called and returns at a negedge; leaves in_valid high so bytes can go back to back.
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit pulse_start,
                           output bit ok);
    bit acc;
    int gap;
    ok  = 1'b0;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    start    = pulse_start;
    for (int t = 0; t < 200; t++) begin
      acc = in_ready;
      @(negedge clk);
      start = 1'b0;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_load(input logic [7:0] lenb, input logic [7:0] cmask, input int max_gap,
                          input int start_at);
    bit ok;
    build(lenb, cmask);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("hold_in_len", cpu_hold, 1);
    check_eq("ready_in_len", in_ready, 1);
    check_eq("flags_cleared", {done, error}, 0);
    foreach (stim_q[i]) begin
      send_byte(stim_q[i], max_gap, (i == start_at), ok);
      check_eq("byte_accepted", ok, 1);
      if (!ok) break;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("done", done, exp_done);
    check_eq("error", error, exp_err);
    check_eq("cpu_hold_end", cpu_hold, exp_err);
    check_eq("ready_end", in_ready, 0);
    check_eq("waddr_end", waddr, exp_waddr_end);
    check_eq("missing_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          n;
    logic [7:0]  lenb, cm;
    int          sa;

    #3 n_rst = 1'b0;
    #1;
    check_eq("reset_outputs", {we, waddr, wdata, in_ready, cpu_hold, done, error}, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // Bytes offered in IDLE must not be taken.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    check_eq("idle_ready", in_ready, 0);
    check_eq("idle_hold", cpu_hold, 0);
    in_valid = 1'b0;

    words_q = '{32'h0000_0013, 32'h0010_0093};
    run_load(8'd2, 8'h00, 0, -1);

    words_q = '{32'hDEAD_BEEF};
    run_load(8'd1, 8'h22, 0, -1);

    run_load(8'h41, 8'h00, 0, -1);

    words_q.delete();
    for (int i = 0; i < 64; i++) words_q.push_back(32'(i));
    run_load(8'd0, 8'h00, 0, -1);

    // Reset in the middle of word 0: no write, everything back to zero.
    words_q = '{32'h0000_0013, 32'h0010_0093};
    build(8'd2, 8'h00);
    exp_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_byte(stim_q[i], 0, 1'b0, ok);
      check_eq("abort_byte", ok, 1);
    end
    in_valid = 1'b0;
    n_rst    = 1'b0;
    #1;
    check_eq("midload_reset", {we, waddr, wdata, in_ready, cpu_hold, done, error}, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    run_load(8'd2, 8'h00, 0, -1);

    // Gaps plus a stray start pulse during DATA.
    run_load(8'd2, 8'h00, 3, 5);

    for (int k = 0; k < 12; k++) begin
      words_q.delete();
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      lenb = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(65, 255)) : 8'(n);
      cm   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      sa   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 4 * n)) : -1;
      run_load(lenb, cm, int'($urandom_range(0, 3)), sa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
